// File: rtl/tl_amo_bridge_if.sv
// tl_amo_bridge_if: TileLink A/D channel bundle between the core data agent
// (master) and the AMO bridge (slave).
interface tl_amo_bridge_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  a_valid;
  logic                  a_ready;
  logic [2:0]            a_opcode;
  logic [2:0]            a_param;
  logic [2:0]            a_size;
  logic [7:0]            a_mask;
  logic [ADDR_WIDTH-1:0] a_address;
  logic [63:0]           a_data;
  logic                  a_corrupt;

  logic                  d_valid;
  logic                  d_ready;
  logic [2:0]            d_size;
  logic [1:0]            d_param;
  logic [63:0]           d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_mask, a_address, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_size, d_param, d_data,
    output d_ready
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_mask, a_address, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_size, d_param, d_data,
    input  d_ready
  );
endinterface

// File: rtl/tl_amo_bridge.sv
// tl_amo_bridge: single-outstanding TileLink slave that turns Get, PutFull,
// arithmetic/logical atomics and LR/SC into read / write / read-modify-write
// sequences on a simple 64-bit word memory port.
// Optional feature macro: LRSC_RESERVATION_EN enables the one-entry LR/SC
// reservation (LR/SC flagged by a_corrupt). Without it LR behaves as Get and
// SC as PutFull.
module tl_amo_bridge #(
  parameter int ADDR_WIDTH   = 64,
  parameter int RSV_GRAIN_LG = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tl_amo_bridge_if.slave        bus,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [63:0]           o_mem_wdata,
  output logic [7:0]            o_mem_wmask,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [63:0]           i_mem_rdata
);

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ARITH       = 3'd2;
  localparam logic [2:0] OP_LOGIC       = 3'd3;
  localparam logic [2:0] OP_GET         = 3'd4;

  localparam logic [2:0] P_MIN  = 3'd0;
  localparam logic [2:0] P_MAX  = 3'd1;
  localparam logic [2:0] P_MINU = 3'd2;
  localparam logic [2:0] P_MAXU = 3'd3;
  localparam logic [2:0] P_ADD  = 3'd4;

  localparam logic [2:0] P_XOR  = 3'd0;
  localparam logic [2:0] P_OR   = 3'd1;
  localparam logic [2:0] P_AND  = 3'd2;
  localparam logic [2:0] P_SWAP = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MOD,
    S_WR,
    S_RESP
  } state_e;

  typedef enum logic [2:0] {
    K_GET,
    K_PUT,
    K_ARITH,
    K_LOGIC,
    K_LR,
    K_SC
  } kind_e;

  state_e                r_state;
  state_e                w_next;
  kind_e                 r_kind;
  kind_e                 w_aKind;
  logic [2:0]            r_param;
  logic [2:0]            r_size;
  logic [7:0]            r_mask;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [63:0]           r_data;
  logic [63:0]           r_old;
  logic [63:0]           r_new;
  logic [63:0]           r_dData;
  logic                  r_rdAcc;

  logic                  w_accept;
  logic                  w_rdDone;
  logic                  w_scHit;
  logic                  w_isAmo;
  logic [7:0]            w_putMask;
  logic [7:0]            w_amoMask;
  logic                  w_word;
  logic [63:0]           w_opA;
  logic [63:0]           w_opB;
  logic [63:0]           w_res;
  logic [63:0]           w_newWord;
  logic                  w_lt;
  logic                  w_ltu;
  logic                  w_unused;

  // Byte-enable pattern of a naturally sized access before lane shifting.
  function automatic logic [7:0] sizeMask(input logic [2:0] size);
    case (size)
      3'd0:    sizeMask = 8'h01;
      3'd1:    sizeMask = 8'h03;
      3'd2:    sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.a_valid;
  assign w_rdDone = (i_mem_ready || r_rdAcc) && i_mem_rvalid;
  assign w_isAmo  = (r_kind == K_ARITH) || (r_kind == K_LOGIC);
  assign w_unused = &{1'b0, bus.a_corrupt, RSV_GRAIN_LG[0]};

  // Classify the incoming A request; a_corrupt marks LR (on Get) and SC (on PutFull).
  always_comb begin
    w_aKind = K_GET;
    case (bus.a_opcode)
      OP_PUT_FULL, OP_PUT_PARTIAL: w_aKind = K_PUT;
      OP_ARITH:                    w_aKind = K_ARITH;
      OP_LOGIC:                    w_aKind = K_LOGIC;
      default:                     w_aKind = K_GET;
    endcase
`ifdef LRSC_RESERVATION_EN
    if (bus.a_corrupt && (bus.a_opcode == OP_GET))      w_aKind = K_LR;
    if (bus.a_corrupt && (bus.a_opcode == OP_PUT_FULL)) w_aKind = K_SC;
`endif
  end

`ifdef LRSC_RESERVATION_EN
  logic                               r_rsvValid;
  logic [ADDR_WIDTH-RSV_GRAIN_LG-1:0] r_rsvTag;
  logic                               w_wrHitsRsv;

  assign w_scHit     = r_rsvValid && (r_rsvTag == bus.a_address[ADDR_WIDTH-1:RSV_GRAIN_LG]);
  assign w_wrHitsRsv = r_rsvValid && (r_rsvTag == r_addr[ADDR_WIDTH-1:RSV_GRAIN_LG]);

  // Reservation: set by a completed LR read, dropped by any SC and by any write into the granule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsvValid <= 1'b0;
      r_rsvTag   <= '0;
    end else if (w_accept && (w_aKind == K_SC)) begin
      r_rsvValid <= 1'b0;
    end else if ((r_state == S_RD) && w_rdDone && (r_kind == K_LR)) begin
      r_rsvValid <= 1'b1;
      r_rsvTag   <= r_addr[ADDR_WIDTH-1:RSV_GRAIN_LG];
    end else if ((r_state == S_WR) && i_mem_ready && w_wrHitsRsv) begin
      r_rsvValid <= 1'b0;
    end
  end
`else
  assign w_scHit = 1'b0;
`endif

  // Atomic ALU: operate on the addressed 32-bit lane or the whole word, then merge back.
  always_comb begin
    w_word = (r_size == 3'd2);
    w_opA  = r_old;
    w_opB  = r_data;
    if (w_word) begin
      w_opA = {32'd0, (r_addr[2] ? r_old[63:32]  : r_old[31:0])};
      w_opB = {32'd0, (r_addr[2] ? r_data[63:32] : r_data[31:0])};
    end
    w_ltu = (w_opA < w_opB);
    w_lt  = w_word ? ($signed(w_opA[31:0]) < $signed(w_opB[31:0]))
                   : ($signed(w_opA) < $signed(w_opB));
    w_res = w_opA;
    if (r_kind == K_ARITH) begin
      case (r_param)
        P_ADD:   w_res = w_opA + w_opB;
        P_MIN:   w_res = w_lt  ? w_opA : w_opB;
        P_MAX:   w_res = w_lt  ? w_opB : w_opA;
        P_MINU:  w_res = w_ltu ? w_opA : w_opB;
        P_MAXU:  w_res = w_ltu ? w_opB : w_opA;
        default: w_res = w_opA;
      endcase
    end else begin
      case (r_param)
        P_XOR:   w_res = w_opA ^ w_opB;
        P_OR:    w_res = w_opA | w_opB;
        P_AND:   w_res = w_opA & w_opB;
        P_SWAP:  w_res = w_opB;
        default: w_res = w_opA;
      endcase
    end
    w_newWord = w_res;
    if (w_word) begin
      w_newWord = r_addr[2] ? {w_res[31:0], r_old[31:0]} : {r_old[63:32], w_res[31:0]};
    end
  end

  // Memory-port write mask and data: atomics cover the op width, puts use the agent's mask.
  always_comb begin
    w_putMask   = (r_mask & sizeMask(r_size)) << r_addr[2:0];
    w_amoMask   = w_word ? (r_addr[2] ? 8'hF0 : 8'h0F) : 8'hFF;
    o_mem_wmask = w_isAmo ? w_amoMask : w_putMask;
    o_mem_wdata = w_isAmo ? r_new : r_data;
    o_mem_addr  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
  end

  // State register; async reset abandons whatever is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and memory strobes; a read request drops once the memory has accepted it.
  always_comb begin
    w_next    = r_state;
    o_mem_req = 1'b0;
    o_mem_we  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.a_valid) begin
          case (w_aKind)
            K_PUT:   w_next = S_WR;
            K_SC:    w_next = w_scHit ? S_WR : S_RESP;
            default: w_next = S_RD;
          endcase
        end
      end
      S_RD: begin
        o_mem_req = !r_rdAcc;
        if (w_rdDone) w_next = w_isAmo ? S_MOD : S_RESP;
      end
      S_MOD: begin
        w_next = S_WR;
      end
      S_WR: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_ready) w_next = S_RESP;
      end
      S_RESP: begin
        if (bus.d_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, read-data capture and ALU result staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind  <= K_GET;
      r_param <= '0;
      r_size  <= '0;
      r_mask  <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_old   <= '0;
      r_new   <= '0;
      r_dData <= '0;
      r_rdAcc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.a_valid) begin
            r_kind  <= w_aKind;
            r_param <= bus.a_param;
            r_size  <= bus.a_size;
            r_mask  <= bus.a_mask;
            r_addr  <= bus.a_address;
            r_data  <= bus.a_data;
            r_rdAcc <= 1'b0;
            r_dData <= '0;
            if ((w_aKind == K_SC) && !w_scHit) begin
              r_dData <= 64'd1 << {bus.a_address[2:0], 3'b000};
            end
          end
        end
        S_RD: begin
          if (i_mem_ready) r_rdAcc <= 1'b1;
          if (w_rdDone) begin
            r_old   <= i_mem_rdata;
            r_dData <= i_mem_rdata;
          end
        end
        S_MOD: begin
          r_new <= w_newWord;
        end
        default: begin
        end
      endcase
    end
  end

  // D channel: beats are lane-aligned, so d_param is always zero.
  assign bus.a_ready = (r_state == S_IDLE);
  assign bus.d_valid = (r_state == S_RESP);
  assign bus.d_size  = r_size;
  assign bus.d_param = 2'b00;
  assign bus.d_data  = r_dData;

endmodule

// File: tb/tb_tl_amo_bridge.sv
// tb_tl_amo_bridge: randomized scoreboard bench for tl_amo_bridge with a
// behavioural memory/reservation model; honours LRSC_RESERVATION_EN.
module tb_tl_amo_bridge;

  localparam int AW = 64;

  localparam logic [2:0] OP_PUT   = 3'd0;
  localparam logic [2:0] OP_ARITH = 3'd2;
  localparam logic [2:0] OP_LOGIC = 3'd3;
  localparam logic [2:0] OP_GET   = 3'd4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tl_amo_bridge_if #(.ADDR_WIDTH(AW)) bus ();

  logic          memReq;
  logic          memWe;
  logic [AW-1:0] memAddr;
  logic [63:0]   memWdata;
  logic [7:0]    memWmask;
  logic          memReady;
  logic          memRvalid;
  logic [63:0]   memRdata;

  tl_amo_bridge #(.ADDR_WIDTH(AW), .RSV_GRAIN_LG(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_mem_req   (memReq),
    .o_mem_we    (memWe),
    .o_mem_addr  (memAddr),
    .o_mem_wdata (memWdata),
    .o_mem_wmask (memWmask),
    .i_mem_ready (memReady),
    .i_mem_rvalid(memRvalid),
    .i_mem_rdata (memRdata)
  );

  typedef struct packed {
    logic [2:0]  size;
    logic [63:0] data;
  } dExp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
  } wExp_t;

  dExp_t       expD[$];
  wExp_t       expW[$];
  logic [63:0] devMem [logic [63:0]];
  logic [63:0] refMem [logic [63:0]];
  bit          rsvValid = 1'b0;
  logic [60:0] rsvTag   = '0;
  bit          memStall = 1'b0;
  int          nCompared   = 0;
  int          nMismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] byteMask(input logic [7:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [63:0] mergeBytes(input logic [63:0] old, input logic [63:0] data,
                                             input logic [7:0] m);
    return (old & ~byteMask(m)) | (data & byteMask(m));
  endfunction

  function automatic logic [63:0] refRead(input logic [63:0] w);
    return refMem.exists(w) ? refMem[w] : 64'd0;
  endfunction

  function automatic logic [63:0] devRead(input logic [63:0] w);
    return devMem.exists(w) ? devMem[w] : 64'd0;
  endfunction

  task automatic preload(input logic [63:0] w, input logic [63:0] v);
    devMem[w] = v;
    refMem[w] = v;
  endtask

  // Atomic result from sign/zero-extended operands using plain integer arithmetic.
  function automatic longint unsigned aluModel(input logic [2:0] opc, input logic [2:0] param,
                                               input longint unsigned ua, input longint unsigned ub,
                                               input longint sa, input longint sb);
    if (opc == OP_ARITH) begin
      case (param)
        3'd0:    return (sa < sb) ? ua : ub;
        3'd1:    return (sa > sb) ? ua : ub;
        3'd2:    return (ua < ub) ? ua : ub;
        3'd3:    return (ua > ub) ? ua : ub;
        default: return ua + ub;
      endcase
    end
    case (param)
      3'd0:    return ua ^ ub;
      3'd1:    return ua | ub;
      3'd2:    return ua & ub;
      default: return ub;
    endcase
  endfunction

  function automatic logic [63:0] amoModel(input logic [2:0] opc, input logic [2:0] param,
                                           input logic [2:0] size, input logic [2:0] off,
                                           input logic [63:0] old, input logic [63:0] data);
    logic [63:0]     r;
    int unsigned     a32;
    int unsigned     b32;
    longint unsigned res;
    r = old;
    if (size == 3'd2) begin
      a32 = old[32*off[2] +: 32];
      b32 = data[32*off[2] +: 32];
      res = aluModel(opc, param, longint'(a32), longint'(b32), longint'(int'(a32)), longint'(int'(b32)));
      r[32*off[2] +: 32] = res[31:0];
    end else begin
      r = aluModel(opc, param, old, data, longint'(old), longint'(data));
    end
    return r;
  endfunction

  task automatic modelWrite(input logic [63:0] w, input logic [7:0] m, input logic [63:0] data);
    wExp_t e;
    e.addr = w;
    e.mask = m;
    e.data = data;
    expW.push_back(e);
    refMem[w] = mergeBytes(refRead(w), data, m);
    if (rsvValid && (rsvTag == w[63:3])) rsvValid = 1'b0;
  endtask

  // Reference model: decides the response beat and memory writes for one request.
  task automatic modelIssue(input logic [2:0] opc, input logic [2:0] param, input logic [2:0] size,
                            input logic [7:0] mask, input logic [63:0] addr,
                            input logic [63:0] data, input bit corrupt);
    logic [63:0] w;
    logic [63:0] old;
    logic [7:0]  pm;
    int          sm;
    bit          isLr;
    bit          isSc;
    dExp_t       d;
    w      = {addr[63:3], 3'b000};
    old    = refRead(w);
    sm     = (1 << (1 << size)) - 1;
    pm     = 8'((int'(mask) & sm) << addr[2:0]);
    d.size = size;
    d.data = '0;
    isLr   = 1'b0;
    isSc   = 1'b0;
`ifdef LRSC_RESERVATION_EN
    isLr = corrupt && (opc == OP_GET);
    isSc = corrupt && (opc == OP_PUT);
`endif
    if (isSc) begin
      if (rsvValid && (rsvTag == addr[63:3])) begin
        rsvValid = 1'b0;
        modelWrite(w, pm, data);
      end else begin
        rsvValid = 1'b0;
        d.data   = 64'd1 << (8 * addr[2:0]);
      end
    end else if (opc == OP_GET) begin
      d.data = old;
      if (isLr) begin
        rsvValid = 1'b1;
        rsvTag   = addr[63:3];
      end
    end else if (opc == OP_PUT) begin
      modelWrite(w, pm, data);
    end else begin
      d.data = old;
      modelWrite(w, (size == 3'd2) ? (8'h0F << (4 * addr[2])) : 8'hFF,
                 amoModel(opc, param, size, addr[2:0], old, data));
    end
    expD.push_back(d);
  endtask

  // Drive one A request (starting at a negedge) and hold it until accepted.
  task automatic applyStimulus(input logic [2:0] opc, input logic [2:0] param, input logic [2:0] size,
                               input logic [7:0] mask, input logic [63:0] addr,
                               input logic [63:0] data, input bit corrupt);
    int waited;
    modelIssue(opc, param, size, mask, addr, data, corrupt);
    bus.a_opcode  = opc;
    bus.a_param   = param;
    bus.a_size    = size;
    bus.a_mask    = mask;
    bus.a_address = addr;
    bus.a_data    = data;
    bus.a_corrupt = corrupt;
    bus.a_valid   = 1'b1;
    waited = 0;
    while (!bus.a_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.a_ready) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL a_accept_timeout: a_ready still 0 after %0d cycles, expected 1", waited);
    end
    @(posedge clk);
    #1;
    bus.a_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expD.size() != 0 || expW.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (expD.size() != 0 || expW.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drain_timeout: %0d beats and %0d writes outstanding, expected 0",
               expD.size(), expW.size());
    end
    @(negedge clk);
  endtask

  // Memory responder: random accept stalls, read data 0..2 cycles after accept, write checking.
  initial begin
    bit          rdPending;
    int          rdDelay;
    int          dly;
    logic [63:0] rdAddr;
    wExp_t       e;
    rdPending = 1'b0;
    rdDelay   = 0;
    rdAddr    = '0;
    memReady  = 1'b0;
    memRvalid = 1'b0;
    memRdata  = '0;
    forever begin
      @(negedge clk);
      memRvalid = 1'b0;
      if (!rst_n) begin
        rdPending = 1'b0;
        memReady  = 1'b0;
      end else begin
        if (rdPending) begin
          if (rdDelay == 0) begin
            memRvalid = 1'b1;
            memRdata  = devRead(rdAddr);
            rdPending = 1'b0;
          end else begin
            rdDelay--;
          end
        end
        memReady = !memStall && ($urandom_range(0, 2) != 0);
        if (memReq && memReady) begin
          if (memWe) begin
            if (expW.size() == 0) begin
              nCompared++;
              nMismatched++;
              $display("[TB] FAIL wr_unexpected: write to 0x%h, expected no write", memAddr);
            end else begin
              e = expW.pop_front();
              checkOutput("wr_addr", memAddr, e.addr);
              checkOutput("wr_mask", 64'(memWmask), 64'(e.mask));
              checkOutput("wr_data", memWdata & byteMask(e.mask), e.data & byteMask(e.mask));
            end
            devMem[{memAddr[63:3], 3'b000}] = mergeBytes(devRead({memAddr[63:3], 3'b000}), memWdata, memWmask);
          end else begin
            checkOutput("rd_addr_low", 64'(memAddr[2:0]), 64'd0);
            rdAddr = memAddr;
            dly    = $urandom_range(0, 2);
            if (dly == 0) begin
              memRvalid = 1'b1;
              memRdata  = devRead(rdAddr);
            end else begin
              rdPending = 1'b1;
              rdDelay   = dly - 1;
            end
          end
        end
      end
    end
  end

  // D monitor: random back-pressure, pop and compare on each handshake.
  initial begin
    dExp_t e;
    bus.d_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.d_ready = rst_n && ($urandom_range(0, 3) != 0);
      if (rst_n && bus.d_valid && bus.d_ready) begin
        if (expD.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL d_unexpected: beat data 0x%h, expected no beat", bus.d_data);
        end else begin
          e = expD.pop_front();
          checkOutput("d_data", bus.d_data, e.data);
          checkOutput("d_size", 64'(bus.d_size), 64'(e.size));
          checkOutput("d_param", 64'(bus.d_param), 64'd0);
        end
      end
    end
  end

  // Main sequence: reset checks, directed cases, random traffic, reset mid-read.
  initial begin
    int          kind;
    logic [2:0]  sz;
    logic [2:0]  off;
    logic [2:0]  prm;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  msk;
    bus.a_valid   = 1'b0;
    bus.a_opcode  = '0;
    bus.a_param   = '0;
    bus.a_size    = '0;
    bus.a_mask    = '0;
    bus.a_address = '0;
    bus.a_data    = '0;
    bus.a_corrupt = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_a_ready", 64'(bus.a_ready), 64'd1);
    checkOutput("rst_d_valid", 64'(bus.d_valid), 64'd0);
    checkOutput("rst_mem_req", 64'(memReq), 64'd0);
    checkOutput("rst_mem_we", 64'(memWe), 64'd0);
    checkOutput("rst_mem_wmask", 64'(memWmask), 64'd0);
    checkOutput("rst_mem_addr", memAddr, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    preload(64'h1000, 64'h1122334455667788);
    applyStimulus(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h1000, 64'd0, 1'b0);
    applyStimulus(OP_PUT, 3'd0, 3'd0, 8'h01, 64'h1003, 64'hAB << 24, 1'b0);
    preload(64'h2000, 64'hFFFFFFFF_12345678);
    applyStimulus(OP_ARITH, 3'd4, 3'd2, 8'h0F, 64'h2004, 64'h00000001_00000000, 1'b0);
    preload(64'h2008, 64'h8000000000000000);
    applyStimulus(OP_ARITH, 3'd0, 3'd3, 8'hFF, 64'h2008, 64'd1, 1'b0);
    applyStimulus(OP_ARITH, 3'd2, 3'd3, 8'hFF, 64'h2008, 64'd1, 1'b0);
    applyStimulus(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h3000, 64'd0, 1'b1);
    applyStimulus(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h3000, 64'hCAFE0000BEEF0001, 1'b1);
    applyStimulus(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h3000, 64'h0123456789ABCDEF, 1'b1);
    applyStimulus(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h3000, 64'd0, 1'b1);
    applyStimulus(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h3000, 64'h5555AAAA5555AAAA, 1'b0);
    applyStimulus(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h3000, 64'h7777777777777777, 1'b1);
    drain();

    for (int i = 0; i < 4; i++) preload(64'h4000 + 64'(i) * 8, {$urandom, $urandom});
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 5);
      addr = 64'h4000 + 64'($urandom_range(0, 3)) * 8;
      data = {$urandom, $urandom};
      sz   = 3'($urandom_range(0, 3));
      off  = 3'(($urandom_range(0, 7) >> sz) << sz);
      msk  = 8'($urandom) & 8'((1 << (1 << sz)) - 1);
      case (kind)
        0: applyStimulus(OP_GET, 3'd0, sz, 8'hFF, addr + 64'(off), 64'd0, 1'b0);
        1: applyStimulus(OP_PUT, 3'd0, sz, msk, addr + 64'(off), data, 1'b0);
        2, 3: begin
          sz  = 3'($urandom_range(2, 3));
          off = (sz == 3'd2) ? 3'(4 * $urandom_range(0, 1)) : 3'd0;
          prm = (kind == 2) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 3));
          applyStimulus((kind == 2) ? OP_ARITH : OP_LOGIC, prm, sz, 8'hFF, addr + 64'(off), data, 1'b0);
        end
        default: begin
          sz  = 3'($urandom_range(2, 3));
          off = (sz == 3'd2) ? 3'(4 * $urandom_range(0, 1)) : 3'd0;
          applyStimulus((kind == 4) ? OP_GET : OP_PUT, 3'd0, sz, 8'hFF, addr + 64'(off), data, 1'b1);
        end
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    applyStimulus(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h3000, 64'd0, 1'b1);
    drain();
    memStall = 1'b1;
    applyStimulus(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h3008, 64'd0, 1'b0);
    checkOutput("mid_rd_mem_req", 64'(memReq), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_mem_req", 64'(memReq), 64'd0);
    checkOutput("async_rst_d_valid", 64'(bus.d_valid), 64'd0);
    expD.delete();
    expW.delete();
    rsvValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_a_ready", 64'(bus.a_ready), 64'd1);
    memStall = 1'b0;
    @(negedge clk);
    applyStimulus(OP_PUT, 3'd0, 3'd3, 8'hFF, 64'h3000, 64'h0F0F0F0F0F0F0F0F, 1'b1);
    applyStimulus(OP_GET, 3'd0, 3'd3, 8'hFF, 64'h3000, 64'd0, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
